// File: rtl/definitions_pkg.sv
// Shared types, immediate range constants and the immediate encoder used by
// imm_encode_packer and its output FIFO.
package definitions_pkg;

  typedef logic [31:0]        word_ut;
  typedef logic signed [31:0] word_st;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  // Signed ranges of the 12-, 13- and 21-bit immediates (alignment is
  // checked separately for the B and J formats).
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4095;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048575;

  // FIFO payload: encoded word plus its error flag.
  typedef struct packed {
    word_ut instr;
    logic   err;
  } enc_entry_s;

  // Scatter imm into the immediate fields of base. A value that does not
  // sign-extend from the format's top bit, a misaligned B/J offset, a U value
  // with low bits set or an unknown format returns base untouched with err=1.
  function automatic enc_entry_s encode_imm(imm_src_e src, word_ut base, word_st imm);
    enc_entry_s e;
    logic       ok;
    word_ut     u;
    u       = imm;
    ok      = 1'b0;
    e.instr = base;
    e.err   = 1'b1;
    case (src)
      IMM_I: begin
        ok      = (u[31:11] == {21{u[11]}});
        e.instr = {u[11:0], base[19:0]};
      end
      IMM_S: begin
        ok      = (u[31:11] == {21{u[11]}});
        e.instr = {u[11:5], base[24:12], u[4:0], base[6:0]};
      end
      IMM_B: begin
        ok      = (u[31:12] == {20{u[12]}}) && !u[0];
        e.instr = {u[12], u[10:5], base[24:12], u[4:1], u[11], base[6:0]};
      end
      IMM_J: begin
        ok      = (u[31:20] == {12{u[20]}}) && !u[0];
        e.instr = {u[20], u[10:1], u[11], u[19:12], base[11:0]};
      end
      IMM_U: begin
        ok      = (u[11:0] == 12'd0);
        e.instr = {u[31:12], base[11:0]};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.instr = base;
    end
    e.err = !ok;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO with wrap-around pointers and valid/ready on
// both sides. Read data is the head entry, forced to zero while empty.
import definitions_pkg::*;

module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = enc_entry_s
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_valid_i,
  output logic wr_ready_o,
  input  T     wr_data_i,
  output logic rd_valid_o,
  input  logic rd_ready_i,
  output T     rd_data_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = wr_valid_i && !full;
  assign pop        = rd_ready_i && !empty;
  assign wr_ready_o = !full;
  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? T'('0) : mem_q[rd_ptr_q];

  // Next pointer and occupancy values; power-of-two depth wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since reads are masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/imm_encode_packer.sv
// Immediate encoder: range-checks a signed immediate against the chosen
// format, scatters it into a base instruction and queues the result in an
// output FIFO. Optional statistics counters are enabled by defining
// IMM_ENCODE_STATS_EN.
import definitions_pkg::*;

module imm_encode_packer #(
  parameter int FIFO_DEPTH = 4
`ifdef IMM_ENCODE_STATS_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  imm_src_e in_imm_src_i,
  input  word_ut   in_base_i,
  input  word_st   in_imm_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output word_ut   out_instr_o,
`ifdef IMM_ENCODE_STATS_EN
  output logic [CNT_W-1:0] enc_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
`endif
  output logic     out_err_o
);

  enc_entry_s enc_d;
  enc_entry_s head;

  assign enc_d       = encode_imm(in_imm_src_i, in_base_i, in_imm_i);
  assign out_instr_o = head.instr;
  assign out_err_o   = head.err;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (enc_entry_s)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_valid_i (in_valid_i),
    .wr_ready_o (in_ready_o),
    .wr_data_i  (enc_d),
    .rd_valid_o (out_valid_o),
    .rd_ready_i (out_ready_i),
    .rd_data_o  (head)
  );

`ifdef IMM_ENCODE_STATS_EN
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             accept;

  assign accept    = in_valid_i && in_ready_o;
  assign enc_cnt_o = enc_cnt_q;
  assign err_cnt_o = err_cnt_q;

  // Saturating counts of accepted requests and of those flagged in error.
  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept && (enc_cnt_q != '1)) enc_cnt_d = enc_cnt_q + CNT_W'(1);
    if (accept && enc_d.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encode_packer.sv
// Self-checking bench for imm_encode_packer: literal encodings, backpressure,
// reset mid-stream, then randomized traffic against a queue-based model.
`timescale 1ns/1ps
import definitions_pkg::*;

module tb_imm_encode_packer;

  localparam int DEPTH = 4;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     in_valid = 1'b0;
  logic     in_ready;
  imm_src_e in_imm_src = IMM_I;
  word_ut   in_base = '0;
  word_st   in_imm = '0;
  logic     out_valid;
  logic     out_ready = 1'b0;
  word_ut   out_instr;
  logic     out_err;
`ifdef IMM_ENCODE_STATS_EN
  logic [15:0] enc_cnt, err_cnt;
  int          m_enc = 0, m_err = 0;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;
  exp_t model_q[$];

  int bnd[13] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                  -1048576, 1048574, 1048576, -1048578};

  imm_encode_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_imm_src_i (in_imm_src),
    .in_base_i    (in_base),
    .in_imm_i     (in_imm),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_instr_o  (out_instr),
`ifdef IMM_ENCODE_STATS_EN
    .enc_cnt_o    (enc_cnt),
    .err_cnt_o    (err_cnt),
`endif
    .out_err_o    (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder written from the field tables with plain arithmetic.
  function automatic exp_t model(input imm_src_e src, input logic [31:0] base, input int imm);
    exp_t        r;
    longint      v;
    logic [31:0] u;
    bit          ok;
    v = imm;
    u = imm;
    ok = 0;
    r.instr = base;
    case (src)
      IMM_I: begin
        ok = (v >= -2048) && (v <= 2047);
        r.instr = (base & 32'h000FFFFF) | ((u & 32'hFFF) << 20);
      end
      IMM_S: begin
        ok = (v >= -2048) && (v <= 2047);
        r.instr = (base & 32'h01FFF07F) | (((u >> 5) & 32'h7F) << 25) | ((u & 32'h1F) << 7);
      end
      IMM_B: begin
        ok = (v >= -4096) && (v <= 4094) && ((u & 1) == 0);
        r.instr = (base & 32'h01FFF07F) | (((u >> 12) & 1) << 31) | (((u >> 11) & 1) << 7)
                | (((u >> 5) & 32'h3F) << 25) | (((u >> 1) & 32'hF) << 8);
      end
      IMM_J: begin
        ok = (v >= -1048576) && (v <= 1048574) && ((u & 1) == 0);
        r.instr = (base & 32'h00000FFF) | (((u >> 20) & 1) << 31) | (((u >> 12) & 32'hFF) << 12)
                | (((u >> 11) & 1) << 20) | (((u >> 1) & 32'h3FF) << 21);
      end
      IMM_U: begin
        ok = ((u & 32'hFFF) == 0);
        r.instr = (base & 32'h00000FFF) | (u & 32'hFFFFF000);
      end
      default: ok = 0;
    endcase
    if (!ok) r.instr = base;
    r.err = !ok;
    return r;
  endfunction

  // Cycle monitor: handshake flags, head data and counters against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        model_q.delete();
`ifdef IMM_ENCODE_STATS_EN
        m_enc = 0;
        m_err = 0;
`endif
      end else begin
        check("mon_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        check("mon_in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
`ifdef IMM_ENCODE_STATS_EN
        check("mon_enc_cnt", 32'(enc_cnt), 32'(m_enc));
        check("mon_err_cnt", 32'(err_cnt), 32'(m_err));
`endif
        if (out_valid && model_q.size() > 0) begin
          check("mon_instr", out_instr, model_q[0].instr);
          check("mon_err", 32'(out_err), 32'(model_q[0].err));
          if (out_ready) void'(model_q.pop_front());
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e = model(in_imm_src, in_base, in_imm);
          model_q.push_back(e);
`ifdef IMM_ENCODE_STATS_EN
          m_enc++;
          if (e.err) m_err++;
`endif
        end
      end
    end
  end

  // Drive one request and wait (bounded) until it is accepted.
  task automatic push_word(input imm_src_e src, input logic [31:0] base, input int imm);
    bit rdy;
    in_valid = 1'b1;
    in_imm_src = src;
    in_base = base;
    in_imm = imm;
    for (int i = 0; i < 50; i++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    errors++;
    $display("FAIL push_timeout: got no accept expected accept within 50 cycles");
  endtask

  // Literal expectation with an empty FIFO: word visible one cycle after accept.
  task automatic lit(input string name, input imm_src_e src, input logic [31:0] base,
                     input int imm, input logic [31:0] exp_instr, input logic exp_err);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_imm_src = src;
    in_base = base;
    in_imm = imm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_instr"}, out_instr, exp_instr);
    check({name, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  function automatic int rand_imm();
    case ($urandom % 6)
      0: return int'($urandom);
      1: return int'($urandom_range(0, 8191)) - 4096;
      2: return bnd[$urandom % 13];
      3: return int'($urandom_range(0, 4194303)) - 2097152;
      4: return int'($urandom & 32'hFFFFF000);
      default: return (int'($urandom_range(0, 4095)) - 2048) * 2;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_instr", out_instr, 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    rst = 1'b0;

    // Hand-computed encodings and error cases.
    lit("i_neg1", IMM_I, 32'h00000093, -1, 32'hFFF00093, 1'b0);
    lit("s_8", IMM_S, 32'h0020A023, 8, 32'h0020A423, 1'b0);
    lit("u_lui", IMM_U, 32'h000000B7, 32'h12345000, 32'h123450B7, 1'b0);
    lit("b_neg4", IMM_B, 32'h00000063, -4, 32'hFE000EE3, 1'b0);
    lit("j_2048", IMM_J, 32'h0000006F, 2048, 32'h0010006F, 1'b0);
    lit("i_2048", IMM_I, 32'h00000093, 2048, 32'h00000093, 1'b1);
    lit("b_6", IMM_B, 32'h00000063, 6, 32'h00000363, 1'b0);
    lit("b_odd", IMM_B, 32'h00000063, 3, 32'h00000063, 1'b1);
    lit("u_low", IMM_U, 32'h000000B7, 1, 32'h000000B7, 1'b1);
    lit("unk_src", imm_src_e'(3'd6), 32'h12345678, 0, 32'h12345678, 1'b1);
    @(posedge clk);
    #1;

    // Backpressure: fill the FIFO, stall, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_word(IMM_I, 32'h00000013 + 32'(i << 7), i * 3 - 5);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_imm_src = IMM_S;
    in_base = 32'h00002023;
    in_imm = 4;
    check("bp_full_with_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #1;
    check("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at occupancy 2 keeps it at 2.
    out_ready = 1'b0;
    push_word(IMM_J, 32'h000000EF, 16);
    push_word(IMM_J, 32'h000000EF, -16);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_imm_src = IMM_B;
      in_base = 32'h00000063;
      in_imm = i * 2;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    push_word(IMM_I, 32'h00000013, 1);
    check("pp_occ3_ready", 32'(in_ready), 32'd1);
    push_word(IMM_I, 32'h00000013, 2);
    check("pp_occ4_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #1;

    // Reset with three queued words.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(IMM_U, 32'h00000037, i << 12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_instr", out_instr, 32'd0);
`ifdef IMM_ENCODE_STATS_EN
    check("mrst_enc_cnt", 32'(enc_cnt), 32'd0);
    check("mrst_err_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    push_word(IMM_I, 32'h00000093, 5);
    push_word(IMM_I, 32'h00000093, 4096);
    push_word(IMM_S, 32'h00002023, -8);
    push_word(IMM_J, 32'h0000006F, 3);
    push_word(IMM_U, 32'h00000037, 32'h7000);
    check("stat_enc5", 32'(enc_cnt), 32'd5);
    check("stat_err2", 32'(err_cnt), 32'd2);
`endif

    // Randomized traffic checked by the monitor.
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom % 4) != 0;
      in_valid = ($urandom % 3) != 0;
      in_imm_src = imm_src_e'(3'($urandom % 8));
      in_base = $urandom;
      in_imm = rand_imm();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    check("final_empty", 32'(out_valid), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encode_packer.md
Name: imm_encode_packer

Overview:
- Streaming encoder: takes a base instruction word, an immediate format (imm_src_e) and a signed immediate value. Checks that the immediate fits the format, then scatters its bits into the instruction's immediate fields.
- Inverse of the core's immediate extension path. Used by the self-test/program loader to build instruction words before they are written to instruction memory.
- Encoded words pass through a small output FIFO with valid/ready on both sides.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o
- in_imm_src_i  in  imm_src_e  target format: IMM_I, IMM_S, IMM_B, IMM_J or IMM_U
- in_base_i  in  word_ut  instruction with opcode/rd/rs/funct fields; its immediate-field bits are ignored
- in_imm_i  in  word_st  signed byte offset or value
- out_valid_o  out  1  encoded word available
- out_ready_i  in  1  consumer takes the word when out_valid_o && out_ready_i
- out_instr_o  out  word_ut  encoded instruction
- out_err_o  out  1  immediate was out of range or misaligned; travels with the word

Behaviour:
- Reset is synchronous. While rst_i is high on a clock edge: FIFO is emptied, out_valid_o=0, in_ready_o=1 on the following cycle, out_instr_o=0, out_err_o=0. Reset mid-stream discards all queued words.
- in_ready_o = !full. It is registered-state derived with no combinational path from out_ready_i.
- On an accepting edge, the encoded word and error flag are pushed. out_valid_o rises the next cycle, giving a latency of 1 cycle when the FIFO is empty.
- Push and pop on the same edge leave the occupancy unchanged. A pop while empty is impossible by construction.
- When full, in_ready_o=0 even if out_ready_i=1 that cycle.
- Throughput is 1 word/cycle while out_ready_i is held high.
- Encoding: bits outside the immediate fields are copied from in_base_i, and the immediate fields are overwritten.
  - I: [31:20]=imm[11:0]. Legal range -2048..2047.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Legal range -2048..2047.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. Legal range -4096..4094, and imm[0] must be 0.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. Legal range -1048576..1048574, and imm[0] must be 0.
  - U: [31:12]=imm[31:12]. imm[11:0] must be 0.
- Range check is a sign-extension test: the imm bits above the format's top bit must all equal that top bit.
- On any violation, or an unknown imm_src value: out_err_o=1 and out_instr_o=in_base_i unmodified.
- out_instr_o and out_err_o are driven from the FIFO head. They hold stable while out_valid_o && !out_ready_i.
- Encode logic is purely combinational ahead of the FIFO write. The only state is the FIFO and the optional counters.

Optional Feature:
- Macro IMM_ENCODE_STATS_EN.
- Defined: adds outputs enc_cnt_o[CNT_W] and err_cnt_o[CNT_W].
  - enc_cnt_o increments on every accepted request; err_cnt_o increments on accepted requests with an error.
  - Both saturate at all-ones, reset to 0, and are updated on the accepting edge.
- Undefined: the ports and counters are absent. Encoder and FIFO behaviour are identical in both cases.

Decomposition:
- definitions_pkg: reuse imm_src_e, word_ut, word_st. Add range constants IMM12_MIN/MAX, IMM13_MIN/MAX, IMM21_MIN/MAX.
- Add a packed struct enc_entry_s {word_ut instr; logic err;} as the FIFO payload.
- Sub-module sync_fifo, parameterised by depth and payload type:
  - count-based full/empty
  - wrap-around read/write pointers
  - the same synchronous reset

Test Plan:
- IMM_I, base 0x00000093, imm -1 -> out_instr_o=0xFFF00093, err=0, out_valid_o one cycle after accept.
- IMM_S base 0x0020A023 imm 8 -> 0x0020A423. IMM_U base 0x000000B7 imm 0x12345000 -> 0x123450B7.
- IMM_B base 0x00000063 imm -4 -> 0xFE000EE3. IMM_J base 0x0000006F imm 2048 -> 0x0010006F.
- Errors:
  - IMM_I imm 2048 -> err=1, instr=0x00000093.
  - IMM_B imm 6 (legal) -> err=0. IMM_B imm 3 (odd) -> err=1.
  - IMM_U imm 0x00000001 -> err=1.
- Backpressure: hold out_ready_i=0 and push FIFO_DEPTH words -> in_ready_o=0 after the 4th. Release -> words drain in order and data stays stable while stalled. Simultaneous push/pop at depth 2 keeps occupancy at 2.
- Assert rst_i with 3 queued words -> next cycle out_valid_o=0, in_ready_o=1. With IMM_ENCODE_STATS_EN, the counters read 0 after reset and show enc=5, err=2 after 5 accepts including 2 errors.
